// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain PS2_CLK/PS2_DAT via drive-low enables.
// Define PS2_TX_TIMEOUT_EN to add a per-transaction watchdog that aborts with an error pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    localparam int TMR_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int TMR_W   = ($clog2(TMR_MAX + 1) < 3) ? 3 : $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(START_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(3);

    if (INHIBIT_CYCLES < 1 || START_HOLD_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_param
        $error("ps2_host_tx: cycle parameters out of range");
    end

    logic             clk_s1_q, clk_s2_q;
    logic             dat_s1_q, dat_s2_q;
    logic             clk_flt_q, clk_flt_d;
    logic [1:0]       flt_cnt_q, flt_cnt_d;
    logic             fall;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       sh_q, sh_d;
    logic             nack_q, nack_d;
    logic             wd_exp;

    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    // A falling edge is reported once the synchronized clock has sat low for 4 straight cycles.
    always_comb begin
        clk_flt_d = clk_flt_q;
        flt_cnt_d = 2'd0;
        fall      = 1'b0;
        if (clk_s2_q != clk_flt_q) begin
            if (flt_cnt_q == 2'd3) begin
                clk_flt_d = clk_s2_q;
                fall      = clk_flt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 2'd1;
            end
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] wd_q, wd_d;
    logic        wd_run;

    assign wd_run = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT);
    assign wd_exp = wd_run && (wd_q == WD_LAST);
    assign wd_d   = wd_run ? (wd_q + 20'd1) : 20'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q <= 20'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_exp = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            clk_flt_q <= 1'b1;
            flt_cnt_q <= 2'd0;
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bitcnt_q  <= 4'd0;
            sh_q      <= 10'd0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_dat_in;
            dat_s2_q  <= dat_s1_q;
            clk_flt_q <= clk_flt_d;
            flt_cnt_q <= flt_cnt_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        nack_d   = nack_q;
        case (state_q)
            S_IDLE: begin
                if (send) begin
                    sh_d     = {1'b1, ~^data_in, data_in};
                    tmr_d    = '0;
                    bitcnt_d = 4'd0;
                    nack_d   = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmr_q == INH_LAST) begin
                    tmr_d   = '0;
                    state_d = S_REQ;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_REQ: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d    = '0;
                    bitcnt_d = 4'd0;
                    state_d  = S_SHIFT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // The stop bit sits at the top of the frame, so the tenth edge releases the line.
                if (fall) begin
                    sh_d     = {1'b0, sh_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    nack_d  = dat_s2_q;
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (clk_s2_q && dat_s2_q) begin
                    if (tmr_q == IDLE_LAST) begin
                        tmr_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else begin
                    tmr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wd_exp) begin
            tmr_d   = '0;
            state_d = S_IDLE;
        end
    end

    always_comb begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_d)
            S_INHIBIT: clk_oe_d = 1'b1;
            S_REQ: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b1;
            end
            S_SHIFT: begin
                if (state_q == S_REQ) begin
                    dat_oe_d = 1'b1;
                end else if (fall) begin
                    dat_oe_d = ~sh_q[0];
                end else begin
                    dat_oe_d = dat_oe_q;
                end
            end
            default: ;
        endcase
        if (state_q != S_IDLE && state_d == S_IDLE) begin
            if (state_q == S_WAIT && !nack_q && !wd_exp) begin
                done_d = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It pairs with keyboard_tracker, which handles device-to-host traffic, so the design can send command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It drives the open-drain PS2_CLK/PS2_DAT lines through drive-low enables, and top level owns the tri-state buffers. keyboard_tracker must ignore the bus while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clock cycles PS2_CLK is held low before the request (100 us at 50 MHz)
START_HOLD_CYCLES, 50, cycles data is held low before clock release (1 us)
TIMEOUT_CYCLES, 750000, watchdog limit per transaction (15 ms), used only with PS2_TX_TIMEOUT_EN

Ports:
clock  input  1  system clock (CLOCK_50)
reset  input  1  asynchronous, active-high reset
send  input  1  one-cycle request strobe; sampled only when busy=0
data_in  input  8  command byte; latched on an accepted send
ps2_clk_in  input  1  raw PS2_CLK pin value (asynchronous)
ps2_dat_in  input  1  raw PS2_DAT pin value (asynchronous)
ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release (Z)
ps2_dat_oe  output  1  1 = drive PS2_DAT low, 0 = release (Z)
busy  output  1  high from the accepted send until done or error
done  output  1  one-cycle pulse: byte sent and device ACK seen
error  output  1  one-cycle pulse: no ACK (or timeout if enabled)

Behaviour:
- Reset (async, active-high): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0; bit counter 0; shift register 0.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
- Clock edge detect: a falling edge is sync_clk going 1->0 and stable for 4 consecutive cycles (glitch filter). Edge latency after the pin changes is at most 7 cycles.
- Frame latched at accept: {stop=1, parity=~^data_in (odd), data_in[7:0]}, shifted out LSB first.
- send while busy=1 is ignored: not queued, no pulse. Accepting send in IDLE sets busy on the next edge.
- FSM:
  IDLE: outputs released. On send: latch the frame, go to INHIBIT.
  INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  REQ: clk_oe=1, dat_oe=1 (start bit 0) for START_HOLD_CYCLES cycles, then clk_oe=0 and go to SHIFT with count=0.
  SHIFT: on each filtered falling edge, present the next frame bit: dat_oe = ~bit. Falling edges 1..8 give data bits 0..7, edge 9 gives parity, edge 10 gives stop (dat_oe=0, line released). Go to ACK after edge 10.
  ACK: on the next falling edge, sample sync_dat. 0 means ACK ok and goes to WAIT_IDLE; 1 sets the nack flag and goes to WAIT_IDLE.
  WAIT_IDLE: wait until sync_clk=1 and sync_dat=1 for 4 consecutive cycles. Then pulse done (ack ok) or error (nack), clear busy, return to IDLE.
- done and error are mutually exclusive and never asserted in the same cycle as busy=1 rising.
- Bit counter is 4 bits, range 0..10, and never wraps. Extra falling edges in WAIT_IDLE are ignored.
- Reset mid-transaction: lines are released immediately (async). No done/error pulse; the device times out on its own.
- ps2_clk_oe and ps2_dat_oe are registered outputs with no combinational path from the pins.

Optional Feature:
Macro PS2_TX_TIMEOUT_EN.
- Defined: a 20-bit watchdog counts from entry into SHIFT. If TIMEOUT_CYCLES is reached before WAIT_IDLE completes, release both lines, pulse error, clear busy, return to IDLE. The counter clears in IDLE.
- Undefined: no watchdog. The block waits indefinitely for device clocks, and only reset recovers it.

Test Plan:
- Reset: assert reset mid-SHIFT -> same cycle clk_oe=0, dat_oe=0, busy=0; no done/error pulse.
- Send 0xED with device model ACKing -> clk_oe low for exactly 5000 cycles; then dat_oe=1; data seen at device rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy cleared.
- Send 0x01 -> parity bit 0; send 0x00 -> parity bit 1; device checks each frame and ACKs -> done for both.
- Device never pulls data low at the 11th clock -> error pulses once, done stays 0, lines released.
- send strobed again at cycle 100 of INHIBIT with 0xFF -> ignored; the transmitted byte remains the first one; exactly one done pulse.
- With PS2_TX_TIMEOUT_EN defined, the device stops clocking after 4 bits -> error at TIMEOUT_CYCLES after SHIFT entry, busy=0. Without the macro, busy stays 1.
